uart_comm: RTL and testbench
============================

# uart_comm

Host-side serial endpoint for the scope's command/response path. It deserializes UART bytes from the host into a 24-bit command, presents it to the digital core with a `cmd_rdy`/`clr_cmd_rdy` handshake, and serializes one-byte responses back to the host on `send_resp`/`resp_sent`. It sits between the board RX/TX pins and the core's `cmd`, `cmd_rdy`, `clr_cmd_rdy`, `resp_data`, `send_resp` and `resp_sent` ports.

## Interface
- `CLKS_PER_BIT`, default 2604, is the number of clk cycles per UART bit (≥ 8).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `RX`  in  1  serial input from host; idles high; asynchronous to `clk`.
- `TX`  out  1  serial output to host; idles high.
- `cmd`  out  24  assembled command; first received byte occupies [23:16].
- `cmd_rdy`  out  1  `cmd` is valid; held until cleared.
- `clr_cmd_rdy`  in  1  one-cycle pulse from the core that consumes the command.
- `resp_data`  in  8  response byte; sampled only when `send_resp` is accepted.
- `send_resp`  in  1  one-cycle request to transmit `resp_data`.
- `resp_sent`  out  1  one-cycle pulse when the stop bit of the response has completed.

## Operation
- **Frame format:** 8N1, LSB first. Bits are 1 start (0), 8 data bits, 1 stop (1).
- **RX synchronizer:** `RX` passes through a 2-flop synchronizer before any other use.
- **RX FSM: IDLE → START → DATA → STOP → IDLE.**
  - IDLE: a falling edge on the synchronized `RX` enters START.
  - START: at the half-bit count (`CLKS_PER_BIT/2`), if `RX` is still 0, go to DATA. Otherwise return to IDLE (glitch rejected).
  - DATA: sample one bit every `CLKS_PER_BIT` cycles, 8 samples total.
  - STOP: sample once. A 1 gives a good byte. A 0 is a framing error: the byte is discarded and the byte index is left unchanged. Return to IDLE in either case.
- **Command assembly:**
  - A 2-bit byte index starts at 0. Each good byte is written to `cmd` at [23:16], then [15:8], then [7:0], and the index advances.
  - After the third byte, `cmd_rdy` is set and the index returns to 0.
  - While `cmd_rdy` = 1, `cmd` is frozen and good bytes are dropped.
- **`clr_cmd_rdy`:** clears `cmd_rdy` and resets the index to 0.
  - If a good byte completes in the same cycle as `clr_cmd_rdy`, that byte is accepted as byte 0 of the next command.
- **TX FSM: IDLE → SEND → IDLE.**
  - In IDLE, `send_resp` = 1 latches `resp_data` into a shift register and enters SEND.
  - SEND shifts out 10 bits, each held for `CLKS_PER_BIT` cycles.
  - `send_resp` while in SEND is ignored. No queueing.
- **RX/TX independence:** RX and TX are fully independent (full duplex).

## Timing
- **Reset values:** `TX` = 1, `cmd` = 0, `cmd_rdy` = 0, `resp_sent` = 0. Both FSMs in IDLE, byte index 0.
- **Reset mid-frame:** a partial byte is discarded. `TX` returns to 1 immediately (asynchronous).
- **`cmd_rdy` latency:** rises on the cycle after the stop-bit sample of the third byte.
- **`cmd_rdy` clear:** low on the cycle after `clr_cmd_rdy`.
- **TX start:** `TX` goes low on the cycle after an accepted `send_resp`.
- **Frame length:** one frame is exactly 10·`CLKS_PER_BIT` cycles of `TX` activity.
- **`resp_sent`:**
  - Pulses high for one cycle, the first cycle back in IDLE, after the full stop-bit period.
  - A `send_resp` in that same cycle is accepted, so back-to-back frames have no idle gap.
- **Counters:**
  - Baud counters are sized for `CLKS_PER_BIT` and reset at every bit boundary.
  - The bit counter is 4 bits wide.
  - No counter wraps silently.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` (IDLE, START, DATA, STOP).
  - `tx_state_t` (IDLE, SEND).
  - Constants `DATA_BITS` = 8 and `CMD_BYTES` = 3.
- **Sub-module `uart_rx`:** contains the synchronizer and RX FSM. It outputs `rx_data[7:0]` plus a one-cycle `rx_rdy` pulse on a good stop bit.
- **`uart_comm` top:** instantiates `uart_rx` and holds the command-assembly logic and the TX FSM inline.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- **Command assembly:** send bytes 0x02, 0x1C, 0xA5 → `cmd_rdy` = 1 one cycle after the third stop sample, with `cmd` = 0x021CA5. Then pulse `clr_cmd_rdy` → `cmd_rdy` = 0 the next cycle.
- **Overrun drop:** hold `cmd_rdy` uncleared and send 0xFF → `cmd` stays 0x021CA5. Then clear and send 0x01, 0x02, 0x03 → `cmd` = 0x010203.
- **Framing errors:**
  - Glitch: a 3-cycle low pulse on `RX` produces no byte.
  - Bad stop: a frame with stop bit 0 between 0xAA and 0xBB is discarded, and the next good byte 0xCC completes `cmd` = 0xAABBCC.
- **Single response:** `send_resp` with `resp_data` = 0xA5 → `TX` emits the levels 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. `resp_sent` pulses once, 160 cycles after `TX` first goes low.
- **Busy / back-to-back:** `send_resp` mid-frame is ignored (only one frame sent). `send_resp` asserted in the `resp_sent` cycle with 0x3C produces a second frame with no high gap.
- **Reset mid-operation:** assert `rst` in the middle of an RX byte and of a TX frame → `TX` = 1 and `cmd_rdy` = 0 immediately. The next 3-byte command is assembled correctly from byte 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM types and framing constants for the UART command endpoint
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CMD_BYTES = 3;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
endpackage

// File: rtl/uart_comm_if.sv
// uart_comm_if: serial pins plus command/response handshake between host link and core
interface uart_comm_if;
  logic RX;
  logic TX;
  logic [23:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic [7:0] resp_data;
  logic send_resp;
  logic resp_sent;
  modport slave(input RX, clr_cmd_rdy, resp_data, send_resp, output TX, cmd, cmd_rdy, resp_sent);
  modport master(output RX, clr_cmd_rdy, resp_data, send_resp, input TX, cmd, cmd_rdy, resp_sent);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: synchronized 8N1 receiver emitting a one-cycle rx_rdy per good byte
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t state, state_nxt;
  logic rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic half, full;
  assign half = baud_cnt == CW'(CLKS_PER_BIT / 2);
  assign full = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign rx_rdy = state == RX_STOP && full && rx_sync;
  // two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
  // rx state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RX_IDLE;
    else state <= state_nxt;
  // start bit is revalidated at mid-bit so short glitches fall back to idle
  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE:  state_nxt = (rx_prev && !rx_sync) ? RX_START : RX_IDLE;
      RX_START: state_nxt = half ? (rx_sync ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  state_nxt = (full && bit_cnt == 4'(DATA_BITS - 1)) ? RX_STOP : RX_DATA;
      RX_STOP:  state_nxt = full ? RX_IDLE : RX_STOP;
    endcase
  end
  // counters restart on every state change and bit boundary; data shifts in LSB first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      baud_cnt <= (state == RX_IDLE || state != state_nxt || full) ? '0 : baud_cnt + 1'b1;
      bit_cnt <= state == RX_DATA ? bit_cnt + 4'(full) : '0;
      if (state == RX_DATA && full) rx_data <= {rx_sync, rx_data[7:1]};
    end
endmodule

// File: rtl/uart_comm.sv
// uart_comm: host UART endpoint assembling 24-bit commands and sending 1-byte responses
module uart_comm import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 2604
) (
  input logic        clk,
  input logic        rst,
  uart_comm_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [7:0] rx_data;
  logic rx_rdy;
  logic [1:0] byte_idx;
  tx_state_t tx_state, tx_state_nxt;
  logic [CW-1:0] tx_baud;
  logic [3:0] tx_bit;
  logic [9:0] tx_shift;
  logic tx_full, tx_last;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rx(bus.RX), .rx_data(rx_data), .rx_rdy(rx_rdy)
  );
  assign tx_full = tx_baud == CW'(CLKS_PER_BIT - 1);
  assign tx_last = tx_full && tx_bit == 4'd9;
  assign bus.TX = tx_shift[0];
  // command assembly; a clear restarts at byte 0 and keeps a byte landing in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.cmd <= '0;
      bus.cmd_rdy <= 1'b0;
      byte_idx <= '0;
    end else if (bus.clr_cmd_rdy) begin
      bus.cmd_rdy <= 1'b0;
      byte_idx <= {1'b0, rx_rdy};
      if (rx_rdy) bus.cmd[23:16] <= rx_data;
    end else if (rx_rdy && !bus.cmd_rdy) begin
      bus.cmd[8 * (CMD_BYTES - 1 - int'(byte_idx)) +: 8] <= rx_data;
      bus.cmd_rdy <= byte_idx == 2'(CMD_BYTES - 1);
      byte_idx <= byte_idx == 2'(CMD_BYTES - 1) ? '0 : byte_idx + 1'b1;
    end
  // tx state register
  always_ff @(posedge clk or posedge rst)
    if (rst) tx_state <= TX_IDLE;
    else tx_state <= tx_state_nxt;
  // requests are only taken from idle; a frame ends after the full stop-bit period
  always_comb begin
    tx_state_nxt = tx_state;
    if (tx_state == TX_IDLE && bus.send_resp) tx_state_nxt = TX_SEND;
    if (tx_state == TX_SEND && tx_last) tx_state_nxt = TX_IDLE;
  end
  // shifter loads {stop, data, start} and backfills ones so the line idles high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_shift <= '1;
      tx_baud <= '0;
      tx_bit <= '0;
      bus.resp_sent <= 1'b0;
    end else begin
      bus.resp_sent <= tx_last;
      tx_baud <= (tx_state == TX_IDLE || tx_full) ? '0 : tx_baud + 1'b1;
      tx_bit <= tx_state == TX_IDLE ? '0 : tx_bit + 4'(tx_full);
      if (tx_state == TX_IDLE && bus.send_resp) tx_shift <= {1'b1, bus.resp_data, 1'b0};
      else if (tx_full) tx_shift <= {1'b1, tx_shift[9:1]};
    end
endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm: directed table-driven bench for the UART command endpoint
module tb_uart_comm;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  uart_comm_if bus();
  uart_comm #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic hold;
    logic [23:0] exp;
  } cmd_vec_t;
  typedef struct {
    logic [7:0] d;
    logic [0:9] lv;
  } tx_vec_t;
  cmd_vec_t cv[3];
  tx_vec_t tv[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RX = f[i];
      idle(CPB);
    end
    bus.RX = 1'b1;
  endtask

  task automatic glitch();
    bus.RX = 1'b0;
    idle(3);
    bus.RX = 1'b1;
    idle(40);
  endtask

  task automatic clear();
    bus.clr_cmd_rdy = 1'b1;
    idle(1);
    bus.clr_cmd_rdy = 1'b0;
    chk("rdy_after_clear", bus.cmd_rdy, 0);
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    chk("tx_idle_before_req", bus.TX, 1);
    bus.send_resp = 1'b1;
    bus.resp_data = d;
    idle(1);
    bus.send_resp = 1'b0;
  endtask

  task automatic check_frame(input logic [0:9] lv, input logic busy, input logic chain, input logic [7:0] nd);
    logic got, early;
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got = lv[i];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (bus.TX !== lv[i]) got = bus.TX;
        early |= bus.resp_sent;
        if (busy && i == 3 && c == 0) begin
          bus.send_resp = 1'b1;
          bus.resp_data = 8'h00;
        end
        if (busy && i == 3 && c == 1) bus.send_resp = 1'b0;
      end
      chk($sformatf("tx_bit%0d", i), got, lv[i]);
    end
    chk("resp_sent_early", early, 0);
    @(negedge clk);
    chk("resp_sent_pulse", bus.resp_sent, 1);
    if (chain) begin
      bus.send_resp = 1'b1;
      bus.resp_data = nd;
      idle(1);
      bus.send_resp = 1'b0;
    end else begin
      @(negedge clk);
      chk("resp_sent_one_cycle", bus.resp_sent, 0);
    end
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_low, saw_sent;
    cv[0] = '{8'h02, 8'h1C, 8'hA5, 1'b1, 24'h021CA5};
    cv[1] = '{8'h01, 8'h02, 8'h03, 1'b0, 24'h010203};
    cv[2] = '{8'hFF, 8'h00, 8'h7E, 1'b0, 24'hFF007E};
    tv[0] = '{8'hA5, 10'b0101001011};
    tv[1] = '{8'h3C, 10'b0001111001};
    tv[2] = '{8'h81, 10'b0100000011};
    bus.RX = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    bus.resp_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", bus.TX, 1);
    chk("reset_cmd", bus.cmd, 0);
    chk("reset_cmd_rdy", bus.cmd_rdy, 0);
    chk("reset_resp_sent", bus.resp_sent, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    for (int v = 0; v < 3; v++) begin
      send_byte(cv[v].b0, 1'b1);
      send_byte(cv[v].b1, 1'b1);
      chk("rdy_after_two_bytes", bus.cmd_rdy, 0);
      send_byte(cv[v].b2, 1'b1);
      chk("rdy_after_three_bytes", bus.cmd_rdy, 1);
      chk("cmd_value", bus.cmd, cv[v].exp);
      if (cv[v].hold) begin
        send_byte(8'hFF, 1'b1);
        chk("overrun_cmd_frozen", bus.cmd, cv[v].exp);
        chk("overrun_rdy_held", bus.cmd_rdy, 1);
      end
      clear();
    end

    glitch();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(CPB);
    send_byte(8'hBB, 1'b1);
    glitch();
    chk("rdy_after_bad_frames", bus.cmd_rdy, 0);
    send_byte(8'hCC, 1'b1);
    chk("rdy_after_framing", bus.cmd_rdy, 1);
    chk("cmd_after_framing", bus.cmd, 24'hAABBCC);
    clear();

    for (int v = 0; v < 3; v++) begin
      send_req(tv[v].d);
      check_frame(tv[v].lv, 1'b0, 1'b0, 8'h00);
    end

    send_req(8'hA5);
    check_frame(tv[0].lv, 1'b1, 1'b1, 8'h3C);
    check_frame(tv[1].lv, 1'b0, 1'b0, 8'h00);
    saw_low = 1'b0;
    saw_sent = 1'b0;
    repeat (200) begin
      @(negedge clk);
      saw_low |= !bus.TX;
      saw_sent |= bus.resp_sent;
    end
    chk("busy_req_not_queued_tx", saw_low, 0);
    chk("busy_req_not_queued_sent", saw_sent, 0);

    idle(1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    chk("rdy_before_reset", bus.cmd_rdy, 1);
    send_req(8'h00);
    bus.RX = 1'b0;
    idle(40);
    @(negedge clk);
    chk("tx_busy_before_reset", bus.TX, 0);
    rst = 1'b1;
    #1;
    chk("reset_mid_tx", bus.TX, 1);
    chk("reset_mid_cmd_rdy", bus.cmd_rdy, 0);
    chk("reset_mid_cmd", bus.cmd, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.RX = 1'b1;
    idle(32);
    chk("tx_idle_after_reset", bus.TX, 1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    chk("rdy_after_reset_cmd", bus.cmd_rdy, 1);
    chk("cmd_after_reset", bus.cmd, 24'h445566);
    clear();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
